gen_ram_arbiter: RTL and testbench

- Two-requester arbiter that shares one single-port gen_ram instance (registered read, write-through q).
- Typical pairing: CPU on port 0, vector generator / DMA on port 1.
- Requests are registered, drive the RAM port, and read data is returned with a valid strobe.
- Lock support for atomic read-modify-write; starvation guard protects port 1.

---
 rtl/gen_ram_arbiter.sv | 99 +++++++++
 tb/tb_gen_ram_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_ram_arbiter.sv
// gen_ram_arbiter: two-requester arbiter sharing one single-port gen_ram, with lock for atomic RMW.
// GEN_RAM_ARB_RR_EN selects round-robin ties instead of fixed priority with a port-1 starvation guard.
module gen_ram_arbiter #(
   parameter int dWidth   = 8,
   parameter int aWidth   = 10,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [aWidth-1:0] p0_addr,
   input  logic [dWidth-1:0] p0_d,
   input  logic              p0_lock,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [dWidth-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [aWidth-1:0] p1_addr,
   input  logic [dWidth-1:0] p1_d,
   input  logic              p1_lock,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [dWidth-1:0] p1_rdata,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [aWidth-1:0] ram_addr,
   output logic [dWidth-1:0] ram_d,
   input  logic [dWidth-1:0] ram_q
);
   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
   state_t state_q, state_d;
   logic gnt0_q, gnt1_q, cs_q, we_q, rv0_q, rv1_q, we_d;
   logic [aWidth-1:0] addr_q, addr_d;
   logic [dWidth-1:0] d_q, d_d;
   logic e0, e1, sel0, sel1, tie1;
   // a port is masked in its own gnt cycle and while the other port owns the lock
   assign e0   = p0_req & ~gnt0_q & (state_q != LOCK1);
   assign e1   = p1_req & ~gnt1_q & (state_q != LOCK0);
   assign sel1 = e1 & (~e0 | tie1);
   assign sel0 = e0 & ~sel1;
`ifdef GEN_RAM_ARB_RR_EN
   logic last_q, last_d;
   assign last_d = sel1 | (last_q & ~sel0);
   assign tie1   = ~last_q;
   always_ff @(posedge clk) last_q <= reset | last_d;
`else
   logic [7:0] wait_q, wait_d;
   assign tie1   = wait_q == 8'(MAX_WAIT);
   assign wait_d = (~p1_req | gnt1_q) ? 8'd0 : tie1 ? wait_q : wait_q + 8'd1;
   always_ff @(posedge clk) wait_q <= reset ? 8'd0 : wait_d;
`endif
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = sel0 & p0_lock ? LOCK0 : sel1 & p1_lock ? LOCK1 : IDLE;
         LOCK0:   state_d = ~p0_lock & (sel0 | ~gnt0_q) ? IDLE : LOCK0;
         LOCK1:   state_d = ~p1_lock & (sel1 | ~gnt1_q) ? IDLE : LOCK1;
         default: state_d = IDLE;
      endcase
      we_d   = sel1 ? p1_we : sel0 & p0_we;
      addr_d = sel1 ? p1_addr : sel0 ? p0_addr : addr_q;
      d_d    = sel1 ? p1_d : sel0 ? p0_d : d_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         cs_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         d_q     <= '0;
         rv0_q   <= 1'b0;
         rv1_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt0_q  <= sel0;
         gnt1_q  <= sel1;
         cs_q    <= sel0 | sel1;
         we_q    <= we_d;
         addr_q  <= addr_d;
         d_q     <= d_d;
         rv0_q   <= gnt0_q & ~we_q;
         rv1_q   <= gnt1_q & ~we_q;
      end
   end
   assign p0_gnt    = gnt0_q;
   assign p1_gnt    = gnt1_q;
   assign p0_rvalid = rv0_q;
   assign p1_rvalid = rv1_q;
   assign p0_rdata  = rv0_q ? ram_q : '0;
   assign p1_rdata  = rv1_q ? ram_q : '0;
   assign ram_cs    = cs_q;
   assign ram_we    = we_q;
   assign ram_addr  = addr_q;
   assign ram_d     = d_q;
endmodule

// File: tb/tb_gen_ram_arbiter.sv
// tb_gen_ram_arbiter: vector table, hand sequences for lock/guard/reset, random traffic vs. a transaction model.
module tb_gen_ram_arbiter;
   localparam int MW = 3;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic p0_req = 1'b0, p0_we = 1'b0, p0_lock = 1'b0, p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
   logic [9:0] p0_addr = '0, p1_addr = '0;
   logic [7:0] p0_d = '0, p1_d = '0;
   logic p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, ram_cs, ram_we;
   logic [7:0] p0_rdata, p1_rdata, ram_d, ram_q;
   logic [9:0] ram_addr;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   gen_ram_arbiter #(.dWidth(8), .aWidth(10), .MAX_WAIT(MW)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_d(p0_d), .p0_lock(p0_lock),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_d(p1_d), .p1_lock(p1_lock),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
   );
   function automatic logic [7:0] init_val(input int a);
      return 8'(a + 'h4A);
   endfunction
   // single-port gen_ram: registered read, write-through q
   logic [7:0] mem [1024];
   bit loaded;
   always @(posedge clk)
      if (!loaded) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
         loaded <= 1'b1;
      end else if (ram_cs) begin
         if (ram_we) begin
            mem[ram_addr] <= ram_d;
            ram_q <= ram_d;
         end else ram_q <= mem[ram_addr];
      end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   // transaction-level model: own shadow memory, grant history, lock owner and wait count
   logic [7:0] sh [1024];
   bit mg[2], mrv[2], mcs, mwe;
   int mown, mwait, mlast;
   logic [9:0] maddr;
   logic [7:0] md, mrd, mpend;
   task automatic model_step();
      bit rq[2], wq[2], lk[2], el[2];
      logic [9:0] ad[2];
      logic [7:0] dd[2];
      int w;
      rq[0] = p0_req; rq[1] = p1_req; wq[0] = p0_we; wq[1] = p1_we;
      lk[0] = p0_lock; lk[1] = p1_lock; ad[0] = p0_addr; ad[1] = p1_addr;
      dd[0] = p0_d; dd[1] = p1_d;
      if (reset) begin
         mg[0] = 0; mg[1] = 0; mrv[0] = 0; mrv[1] = 0; mcs = 0; mwe = 0;
         maddr = '0; md = '0; mown = -1; mwait = 0; mlast = 1;
         return;
      end
      for (int k = 0; k < 2; k++) mrv[k] = mg[k] && !mwe;
      mrd = mpend;
      for (int k = 0; k < 2; k++) el[k] = rq[k] && !mg[k] && (mown < 0 || mown == k);
      if (el[0] && el[1])
`ifdef GEN_RAM_ARB_RR_EN
         w = (mlast == 1) ? 0 : 1;
`else
         w = (mwait == MW) ? 1 : 0;
`endif
      else w = el[0] ? 0 : el[1] ? 1 : -1;
      if (mown < 0) begin
         if (w >= 0 && lk[w]) mown = w;
      end else if (!lk[mown] && (w == mown || !mg[mown])) mown = -1;
      mwait = (!rq[1] || mg[1]) ? 0 : (mwait < MW ? mwait + 1 : MW);
      mcs = w >= 0;
      mwe = 0;
      for (int k = 0; k < 2; k++) mg[k] = (w == k);
      if (w >= 0) begin
         mlast = w;
         mwe = wq[w];
         maddr = ad[w];
         md = dd[w];
         if (wq[w]) sh[ad[w]] = dd[w];
         else mpend = sh[ad[w]];
      end
   endtask
   task automatic cmp_model();
      chk("m_gnt0", 32'(p0_gnt), 32'(mg[0]));
      chk("m_gnt1", 32'(p1_gnt), 32'(mg[1]));
      chk("m_cs", 32'(ram_cs), 32'(mcs));
      chk("m_we", 32'(ram_we), 32'(mwe));
      chk("m_rv0", 32'(p0_rvalid), 32'(mrv[0]));
      chk("m_rv1", 32'(p1_rvalid), 32'(mrv[1]));
      if (mcs) begin
         chk("m_addr", 32'(ram_addr), 32'(maddr));
         chk("m_d", 32'(ram_d), 32'(md));
      end
      if (mrv[0]) chk("m_rdata0", 32'(p0_rdata), 32'(mrd));
      if (mrv[1]) chk("m_rdata1", 32'(p1_rdata), 32'(mrd));
   endtask
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      cmp_model();
   endtask
   task automatic set0(input bit r, input bit w, input bit l, input logic [9:0] a, input logic [7:0] d);
      p0_req = r; p0_we = w; p0_lock = l; p0_addr = a; p0_d = d;
   endtask
   task automatic set1(input bit r, input bit w, input bit l, input logic [9:0] a, input logic [7:0] d);
      p1_req = r; p1_we = w; p1_lock = l; p1_addr = a; p1_d = d;
   endtask
   task automatic exp_o(input string nm, input bit g0, input bit g1, input bit v0, input bit v1);
      chk({nm, "_gnt0"}, 32'(p0_gnt), 32'(g0));
      chk({nm, "_gnt1"}, 32'(p1_gnt), 32'(g1));
      chk({nm, "_rv0"}, 32'(p0_rvalid), 32'(v0));
      chk({nm, "_rv1"}, 32'(p1_rvalid), 32'(v1));
   endtask
   typedef struct {
      bit r0, w0, l0; logic [9:0] a0; logic [7:0] d0;
      bit r1, w1, l1; logic [9:0] a1; logic [7:0] d1;
      bit g0, g1, v0, v1; logic [7:0] rd;
   } vec_t;
   vec_t tv[12];
   bit pend[2];
   initial begin
      for (int i = 0; i < 1024; i++) sh[i] = init_val(i);
      // port 0 read of preloaded 0x010, write 0x33 to 0x004 then port 1 reads it back, then both streaming
      tv[0]  = '{1'b1, 1'b0, 1'b0, 10'h010, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tv[1]  = '{1'b1, 1'b0, 1'b0, 10'h010, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A};
      tv[2]  = '{1'b1, 1'b1, 1'b0, 10'h004, 8'h33, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tv[3]  = '{1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, 10'h004, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
      tv[4]  = '{1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
      tv[5]  = '{1'b1, 1'b0, 1'b0, 10'h010, 8'h00, 1'b1, 1'b0, 1'b0, 10'h004, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tv[6]  = '{1'b1, 1'b0, 1'b0, 10'h010, 8'h00, 1'b1, 1'b0, 1'b0, 10'h004, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A};
      tv[7]  = '{1'b1, 1'b0, 1'b0, 10'h010, 8'h00, 1'b1, 1'b0, 1'b0, 10'h004, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33};
      tv[8]  = '{1'b1, 1'b0, 1'b0, 10'h010, 8'h00, 1'b1, 1'b0, 1'b0, 10'h004, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A};
      tv[9]  = '{1'b1, 1'b0, 1'b0, 10'h010, 8'h00, 1'b1, 1'b0, 1'b0, 10'h004, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33};
      tv[10] = '{1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A};
      tv[11] = '{1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tick();
      tick();
      exp_o("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_cs", 32'(ram_cs), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_d", 32'(ram_d), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         set0(tv[i].r0, tv[i].w0, tv[i].l0, tv[i].a0, tv[i].d0);
         set1(tv[i].r1, tv[i].w1, tv[i].l1, tv[i].a1, tv[i].d1);
         tick();
         exp_o($sformatf("tv%0d", i), tv[i].g0, tv[i].g1, tv[i].v0, tv[i].v1);
         if (tv[i].v0) chk($sformatf("tv%0d_rd0", i), 32'(p0_rdata), 32'(tv[i].rd));
         if (tv[i].v1) chk($sformatf("tv%0d_rd1", i), 32'(p1_rdata), 32'(tv[i].rd));
         if (i == 0) chk("tv0_addr", 32'(ram_addr), 32'h010);
         if (i == 0) chk("tv0_cs", 32'(ram_cs), 32'd1);
      end
      // port 1 locked read then unlocking write holds off port 0
      set1(1'b1, 1'b0, 1'b1, 10'h004, 8'h00);
      tick();
      exp_o("lk_a", 1'b1 ^ 1'b1, 1'b1, 1'b0, 1'b0);
      set1(1'b1, 1'b1, 1'b0, 10'h020, 8'h77);
      set0(1'b1, 1'b0, 1'b0, 10'h010, 8'h00);
      tick();
      exp_o("lk_b", 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lk_b_rd1", 32'(p1_rdata), 32'h33);
      tick();
      exp_o("lk_c", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("lk_c_we", 32'(ram_we), 32'd1);
      set1(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
      tick();
      exp_o("lk_d", 1'b1, 1'b0, 1'b0, 1'b0);
      set0(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
      tick();
      exp_o("lk_e", 1'b0, 1'b0, 1'b1, 1'b0);
      chk("lk_e_rd0", 32'(p0_rdata), 32'h5A);
      // port 1 waits out a port 0 lock, then wins the first tie after release
      set0(1'b1, 1'b0, 1'b1, 10'h010, 8'h00);
      tick();
      exp_o("gd_a", 1'b1, 1'b0, 1'b0, 1'b0);
      set0(1'b0, 1'b0, 1'b1, 10'h000, 8'h00);
      set1(1'b1, 1'b0, 1'b0, 10'h020, 8'h00);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("gd_hold%0d_gnt1", i), 32'(p1_gnt), 32'd0);
      end
      p0_lock = 1'b0;
      tick();
      chk("gd_rel_gnt1", 32'(p1_gnt), 32'd0);
      set0(1'b1, 1'b0, 1'b0, 10'h010, 8'h00);
      tick();
      exp_o("gd_tie", 1'b0, 1'b1, 1'b0, 1'b0);
      set1(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
      tick();
      exp_o("gd_next", 1'b1, 1'b0, 1'b0, 1'b1);
      chk("gd_rd1", 32'(p1_rdata), 32'h77);
      set0(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
      tick();
      tick();
      // tie right after a lone port 0 issue: fixed priority keeps port 0, round-robin picks port 1
      set0(1'b1, 1'b0, 1'b0, 10'h010, 8'h00);
      tick();
      exp_o("rr_a", 1'b1, 1'b0, 1'b0, 1'b0);
      set0(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
      tick();
      set0(1'b1, 1'b0, 1'b0, 10'h010, 8'h00);
      set1(1'b1, 1'b0, 1'b0, 10'h004, 8'h00);
      tick();
`ifdef GEN_RAM_ARB_RR_EN
      exp_o("rr_tie", 1'b0, 1'b1, 1'b0, 1'b0);
`else
      exp_o("rr_tie", 1'b1, 1'b0, 1'b0, 1'b0);
`endif
      set0(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
      set1(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
      tick();
      tick();
      tick();
      // reset in the gnt cycle of a read drops the rvalid; held req re-issues after release
      set0(1'b1, 1'b0, 1'b0, 10'h010, 8'h00);
      tick();
      exp_o("rs_a", 1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      exp_o("rs_b", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rs_b_cs", 32'(ram_cs), 32'd0);
      chk("rs_b_addr", 32'(ram_addr), 32'd0);
      reset = 1'b0;
      tick();
      exp_o("rs_c", 1'b1, 1'b0, 1'b0, 1'b0);
      set0(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
      tick();
      exp_o("rs_d", 1'b0, 1'b0, 1'b1, 1'b0);
      chk("rs_d_rd0", 32'(p0_rdata), 32'h5A);
      // random traffic, requests held until granted, occasional locks and resets
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         if (p0_gnt) pend[0] = 1'b0;
         if (p1_gnt) pend[1] = 1'b0;
         if (!pend[0] && $urandom_range(0, 1) == 1) begin
            pend[0] = 1'b1;
            set0(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), 10'($urandom_range(0, 15)), 8'($urandom));
         end
         if (!pend[1] && $urandom_range(0, 1) == 1) begin
            pend[1] = 1'b1;
            set1(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), 10'($urandom_range(0, 15)), 8'($urandom));
         end
         if (!pend[0]) set0(1'b0, 1'b0, 1'b0, p0_addr, p0_d);
         if (!pend[1]) set1(1'b0, 1'b0, 1'b0, p1_addr, p1_d);
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
